baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 115 +++++++++++
 tb/tb_baud_gen_frac.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : baud_gen_frac
//  Purpose  : Fractional-N baud-rate generator. Produces an oversample tick
//             whose period alternates between act_int and act_int+1 clk
//             cycles so that the average period is act_int + act_frac/2^FRAC_W.
//             Baud-period pulses (centre and end) and a baud square wave are
//             derived from an oversample counter.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous active-high reset
//             en        - generator enable
//             load      - one-cycle strobe latching div_int/div_frac
//             div_int   - integer oversample period, clk cycles
//             div_frac  - fractional period, units of 2^-FRAC_W cycles
//             sync      - phase restart
//             tick_os   - pulse at OVERSAMPLE x baud
//             mid_tick  - pulse at the centre of each baud period
//             bclk_tick - pulse at the end of each baud period
//             bclk      - baud-rate square wave (low first half, high second)
//             cfg_err   - sticky flag, set by a rejected divisor load
//  Revision : 1.0 - initial release
// ============================================================================
module baud_gen_frac #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int DEF_INT    = 27,
  parameter int DEF_FRAC   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              sync,
  output logic              tick_os,
  output logic              mid_tick,
  output logic              bclk_tick,
  output logic              bclk,
  output logic              cfg_err
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              ext;
  logic [OS_W-1:0]   os_cnt;

  logic              load_ok;
  logic [DIV_W:0]    cnt_target;
  logic              tick;
  logic [FRAC_W:0]   frac_sum;

  // Divisors below 2 would give a zero-length or single-cycle period that the
  // counter compare cannot represent, so they are refused.
  assign load_ok    = load && (div_int >= DIV_W'(2));

  // The extra cycle owed by the last accumulator carry stretches this period.
  assign cnt_target = {1'b0, act_int} + (DIV_W+1)'(ext) - (DIV_W+1)'(1);

  assign tick       = en && !load && !sync && (cnt == cnt_target);
  assign frac_sum   = {1'b0, frac_acc} + {1'b0, act_frac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int  <= DIV_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      cnt      <= '0;
      frac_acc <= '0;
      ext      <= 1'b0;
      os_cnt   <= '0;
      cfg_err  <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        act_int  <= div_int;
        act_frac <= div_frac;
        cnt      <= '0;
        frac_acc <= '0;
        ext      <= 1'b0;
        os_cnt   <= '0;
        cfg_err  <= 1'b0;
      end else begin
        // Rejected divisor: everything, counters included, holds this cycle.
        cfg_err  <= 1'b1;
      end
    end else if (sync || !en) begin
      cnt      <= '0;
      frac_acc <= '0;
      ext      <= 1'b0;
      os_cnt   <= '0;
    end else if (tick) begin
      cnt      <= '0;
      frac_acc <= frac_sum[FRAC_W-1:0];
      ext      <= frac_sum[FRAC_W];
      // OVERSAMPLE is a power of two, so natural wrap gives the modulo.
      os_cnt   <= os_cnt + OS_W'(1);
    end else begin
      cnt      <= cnt + (DIV_W+1)'(1);
    end
  end

  assign tick_os   = tick;
  assign mid_tick  = tick && (os_cnt == OS_MID);
  assign bclk_tick = tick && (os_cnt == OS_LAST);
  assign bclk      = en && (os_cnt >= OS_HALF);

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baud_gen_frac
//  Purpose  : Self-checking bench for baud_gen_frac. Expected tick cycles are
//             queued when stimulus is applied; a negedge monitor pops and
//             compares them whenever the DUT pulses tick_os.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic        sync;
  logic        tick_os;
  logic        mid_tick;
  logic        bclk_tick;
  logic        bclk;
  logic        cfg_err;

  baud_gen_frac dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .sync      (sync),
    .tick_os   (tick_os),
    .mid_tick  (mid_tick),
    .bclk_tick (bclk_tick),
    .bclk      (bclk),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int vectors = 0;
  int fails   = 0;
  bit chk_on  = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int cyc;
    bit mid;
    bit bt;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input bit m, input bit b);
    exp_t e;
    e.cyc = c;
    e.mid = m;
    e.bt  = b;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 8'(df);
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic close_window(input string tag);
    chk(tag, q.size(), 0);
    chk_on = 1'b0;
    q.delete();
  endtask

  // Scoreboard monitor: every pulse seen while checking is active must match
  // the head of the expectation queue.
  always @(negedge clk) begin
    if (chk_on && (tick_os || mid_tick || bclk_tick)) begin
      chk("tick_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("tick_os_cycle", cyc, e.cyc);
        chk("tick_os_level", tick_os, 1);
        chk("mid_tick", mid_tick, e.mid);
        chk("bclk_tick", bclk_tick, e.bt);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, n, m, s, e, f, t;
    bit found;
    int per [10];

    rst = 1'b1; en = 1'b1; load = 1'b0; sync = 1'b0;
    div_int = '0; div_frac = '0;

    // Reset state with enable high.
    steps(2);
    chk("rst_tick_os", tick_os, 0);
    chk("rst_mid_tick", mid_tick, 0);
    chk("rst_bclk_tick", bclk_tick, 0);
    chk("rst_bclk", bclk, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Release: default divisor 27/32, first ticks 27 cycles apart.
    rst = 1'b0;
    x = cyc;
    chk("rel_tick_os", tick_os, 0);
    chk("rel_bclk", bclk, 0);
    chk_on = 1'b1;
    push(x + 26, 0, 0);
    push(x + 53, 0, 0);
    steps(56);
    close_window("rel_window_drained");

    // Integer divisor 4: 64-cycle baud, mid at tick 8, end at tick 16.
    n = cyc;
    do_load(4, 0);
    chk_on = 1'b1;
    for (int k = 1; k <= 17; k++) push(n + 4 * k, (k == 8), (k == 16));
    for (int i = 0; i < 70; i++) begin
      chk("bclk_int", bclk, ((cyc - n) >= 33) && ((cyc - n) <= 64));
      step();
    end
    close_window("int_window_drained");
    chk("int_cfg_err", cfg_err, 0);

    // Fractional divisor 4 + 128/256: periods 4,4,5,4,5,...
    n = cyc;
    do_load(4, 128);
    chk_on = 1'b1;
    per = '{4, 4, 5, 4, 5, 4, 5, 4, 5, 4};
    t = n;
    for (int k = 0; k < 10; k++) begin
      t = t + per[k];
      push(t, (k == 7), 0);
    end
    steps(45);
    close_window("frac_window_drained");

    // Rejected divisor keeps the running divisor.
    n = cyc;
    do_load(8, 0);
    steps(2);
    do_load(1, 0);
    chk("reject_cfg_err_set", cfg_err, 1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (tick_os) found = 1'b1;
      else step();
    end
    chk("reject_tick_found", found, 1);
    t = cyc;
    step();
    chk_on = 1'b1;
    push(t + 8, 0, 0);
    push(t + 16, 0, 0);
    steps(16);
    close_window("reject_window_drained");
    chk("reject_cfg_err_sticky", cfg_err, 1);

    // Valid reload clears the error; then sync while os_cnt = 9.
    m = cyc;
    do_load(6, 0);
    chk("reload_cfg_err_clear", cfg_err, 0);
    chk_on = 1'b1;
    for (int k = 1; k <= 9; k++) push(m + 6 * k, (k == 8), 0);
    s = m + 58;
    for (int k = 1; k <= 16; k++) push(s + 6 * k, (k == 8), (k == 16));
    steps(s - cyc);
    sync = 1'b1;
    chk("sync_cycle_tick_os", tick_os, 0);
    step();
    sync = 1'b0;
    steps(s + 98 - cyc);
    close_window("sync_window_drained");

    // Disabled for 100 cycles, with a load accepted midway.
    e = cyc;
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("dis_outputs", {tick_os, mid_tick, bclk_tick, bclk}, 0);
      if (i == 50) begin
        div_int  = 16'd5;
        div_frac = 8'd0;
        load     = 1'b1;
      end else begin
        load     = 1'b0;
      end
      step();
    end
    load = 1'b0;
    f = cyc;
    chk("dis_elapsed", f - e, 100);
    en = 1'b1;
    chk_on = 1'b1;
    push(f + 4, 0, 0);
    push(f + 9, 0, 0);
    steps(11);
    close_window("en_window_drained");

    // Set the error flag, run into the second half of the baud period, then
    // reset asynchronously.
    steps(f + 20 - cyc);
    do_load(0, 0);
    chk("pre_rst_cfg_err", cfg_err, 1);
    steps(f + 45 - cyc);
    chk("pre_rst_bclk", bclk, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tick_os", tick_os, 0);
    chk("async_rst_bclk", bclk, 0);
    chk("async_rst_mid_bclk_tick", {mid_tick, bclk_tick}, 0);
    chk("async_rst_cfg_err", cfg_err, 0);
    step();
    step();
    rst = 1'b0;
    x = cyc;
    chk("rel2_tick_os", tick_os, 0);
    chk("rel2_bclk", bclk, 0);
    chk_on = 1'b1;
    push(x + 26, 0, 0);
    push(x + 53, 0, 0);
    steps(56);
    close_window("rel2_window_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
